uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width (5-9 bits), optional odd/even parity, 1 or 2 stop bits, a 2-flop input synchroniser, and parity/framing error reporting. Sits between the async serial pin and the byte-level consumer (command parser / RX FIFO). Emits one-cycle done pulses with data and error flags.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division), must be >= 4
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_serial  input  1  asynchronous serial line, idle high
rx_active  output  1  high from start-bit detection to end of frame
rx_data  output  DATA_BITS  last received word, LSB first on the wire
rx_done  output  1  one-cycle pulse, frame complete
rx_parity_err  output  1  parity mismatch, valid with rx_done
rx_frame_err  output  1  stop bit sampled low, valid with rx_done

Behaviour:
- Reset: synchronous, active-high; all outputs 0, state IDLE, synchroniser flops set to 1. Reset mid-frame aborts immediately; no rx_done for the partial frame.
- Sync: rx_serial passes two flops (rx_s). All decisions use rx_s (2-cycle pipeline latency).
- Counter width: $clog2(CLKS_PER_BIT)+1 bits. bit_index: $clog2(DATA_BITS)+1 bits.
- States: IDLE, START, DATA, PARITY, STOP, CLEAN, WAIT_IDLE.
- IDLE: rx_done=0. When rx_s==0: load clk_count=CLKS_PER_BIT/2-1, set rx_active=1, go to START.
- START: count down to 0, then sample. rx_s==0 -> DATA, clk_count=CLKS_PER_BIT-1, bit_index=0. rx_s==1 -> glitch: rx_active=0, back to IDLE, no flags.
- DATA: at count 0, shift rx_s into buffer[bit_index]. Reload CLKS_PER_BIT-1 each bit. After bit DATA_BITS-1 go to PARITY if PARITY!=0, else STOP.
- PARITY: at count 0, sample bit p. Error if (XOR of data bits ^ p) != (PARITY==1 ? 1 : 0).
- STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any low sample sets the frame error.
- Completion: on the cycle after the last stop sample, enter CLEAN and:
  - pulse rx_done=1;
  - load rx_data=buffer;
  - drive rx_parity_err and rx_frame_err;
  - set rx_active=0.
  - Data is delivered even when an error flag is set.
- rx_parity_err and rx_frame_err hold their values until the next rx_done.
- CLEAN (one cycle): rx_done=0. Go to WAIT_IDLE if a frame error occurred, else IDLE.
- WAIT_IDLE: stay until rx_s==1, then IDLE. This prevents a break condition from re-triggering endlessly.
- Back-to-back frames: a start edge seen in IDLE the cycle after CLEAN must be caught. No inter-frame gap is required beyond the stop bit(s).

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: keep a 3-entry shift register of rx_s. Every sample point (start verify, data, parity, stop) uses the majority of the values at cycles mid-2, mid-1 and mid.
- Undefined: single sample of rx_s at mid.
- Sample timing and latency are identical in both builds.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (10 clks/bit), 8N1, send 0xA5 -> one rx_done pulse, rx_data=0xA5, both error flags 0, rx_active high for the frame duration.
- DATA_BITS=7, PARITY=2 (even):
  - send 0x35 with parity bit 0 -> rx_data=0x35, rx_parity_err=0;
  - same frame with parity bit 1 -> rx_parity_err=1, rx_data=0x35.
- 8N1, send 0x3C with stop bit driven low, hold line low 30 clks, then high -> rx_done with rx_frame_err=1, rx_data=0x3C. No second rx_done until a new start bit arrives after the line returns high.
- 3-cycle low glitch on idle line -> rx_active pulses then drops, no rx_done. A following 0x55 is received correctly.
- STOP_BITS=2: frames 0x01 and 0xFE sent back-to-back -> two rx_done pulses with correct data. Second stop bit low -> rx_frame_err=1.
- Assert rst during bit 4 of 0xFF -> outputs 0, state IDLE, no rx_done. Next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// Latency: 2-cycle input synchroniser; rx_done pulses the cycle after the last stop-bit sample.
// No backpressure: rx_done is a one-cycle pulse and the consumer must take rx_data then.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote at every sample point.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic                 rx_active,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  // Required XOR of data bits and parity bit: 1 for odd parity, 0 for even.
  localparam logic PAR_TARGET = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEAN, S_WAIT_IDLE
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   sample;
  logic [CW-1:0]          clk_count;
  logic [BW-1:0]          bit_index;
  logic [DATA_BITS-1:0]   buffer;
  logic                   stop_cnt;
  logic                   par_err;
  logic                   frm_err;
  logic                   count_done;
  logic                   stop_last;
  logic                   par_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // rx_hist[0] holds rx_s from one cycle ago, rx_hist[1] from two cycles ago.
  logic [1:0] rx_hist;

  // History of the synchronised line for the majority vote.
  always_ff @(posedge clk) begin
    if (rst) rx_hist <= 2'b11;
    else     rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  assign count_done = (clk_count == '0);
  assign stop_last  = (STOP_BITS == 1) | stop_cnt;
  assign par_bad    = ((^buffer) ^ sample) != PAR_TARGET;

  // Frame state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      clk_count     <= '0;
      bit_index     <= '0;
      buffer        <= '0;
      stop_cnt      <= 1'b0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      rx_active     <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            clk_count <= HALF_LOAD;
            rx_active <= 1'b1;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (!count_done) begin
            clk_count <= clk_count - 1'b1;
          end else if (!sample) begin
            clk_count <= BIT_LOAD;
            bit_index <= '0;
            state     <= S_DATA;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            rx_active <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!count_done) begin
            clk_count <= clk_count - 1'b1;
          end else begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (bit_index == BW'(i)) buffer[i] <= sample;
            end
            clk_count <= BIT_LOAD;
            if (bit_index == LAST_BIT) begin
              stop_cnt <= 1'b0;
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (!count_done) begin
            clk_count <= clk_count - 1'b1;
          end else begin
            par_err   <= par_bad;
            clk_count <= BIT_LOAD;
            state     <= S_STOP;
          end
        end
        S_STOP: begin
          if (!count_done) begin
            clk_count <= clk_count - 1'b1;
          end else if (stop_last) begin
            rx_done       <= 1'b1;
            rx_data       <= buffer;
            rx_parity_err <= par_err;
            rx_frame_err  <= frm_err | ~sample;
            rx_active     <= 1'b0;
            state         <= S_CLEAN;
          end else begin
            frm_err   <= frm_err | ~sample;
            stop_cnt  <= 1'b1;
            clk_count <= BIT_LOAD;
          end
        end
        S_CLEAN: begin
          // A framing error may be a break; wait for the line to go idle first.
          state <= rx_frame_err ? S_WAIT_IDLE : S_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances (8N1, 7E1, 8N2, 9O1) at 10 clocks per bit,
// a vector table with hand-computed expectations, hand sequences for glitch / break / reset,
// and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       flip;
    logic [1:0] stops;
    int         gap;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rx_line = 4'hF;
  logic [3:0] done, active, perr, ferr;
  logic [7:0] d0_data;
  logic [6:0] d1_data;
  logic [7:0] d2_data;
  logic [8:0] d3_data;
  logic [8:0] dat [4];

  int   checks = 0;
  int   errors = 0;
  int   done_cnt [4];
  int   act_cnt [4];
  rec_t rq [$];

  assign dat[0] = {1'b0, d0_data};
  assign dat[1] = {2'b0, d1_data};
  assign dat[2] = {1'b0, d2_data};
  assign dat[3] = d3_data;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx_serial(rx_line[0]), .rx_active(active[0]), .rx_data(d0_data),
    .rx_done(done[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx_serial(rx_line[1]), .rx_active(active[1]), .rx_data(d1_data),
    .rx_done(done[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx_serial(rx_line[2]), .rx_active(active[2]), .rx_data(d2_data),
    .rx_done(done[2]), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .rst(rst), .rx_serial(rx_line[3]), .rx_active(active[3]), .rx_data(d3_data),
    .rx_done(done[3]), .rx_parity_err(perr[3]), .rx_frame_err(ferr[3]));

  // Capture every completed frame and count active cycles, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i] === 1'b1) begin
        rq.push_back('{inst: i, data: dat[i], perr: perr[i], ferr: ferr[i]});
        done_cnt[i]++;
      end
      if (active[i] === 1'b1) act_cnt[i]++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int cfg_bits(input int c);
    case (c)
      0: return 8;
      1: return 7;
      2: return 8;
      default: return 9;
    endcase
  endfunction

  function automatic int cfg_par(input int c);
    case (c)
      1: return 2;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_stop(input int c);
    return (c == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] cfg_mask(input int c);
    return 9'((1 << cfg_bits(c)) - 1);
  endfunction

  // Frame span of rx_active: half a bit to the start-bit centre, then one bit per remaining field.
  function automatic int span(input int c);
    return (cfg_bits(c) + ((cfg_par(c) != 0) ? 1 : 0) + cfg_stop(c)) * CPB + CPB / 2;
  endfunction

  // Correct parity bit for the word (total count of ones odd/even), optionally inverted.
  function automatic logic par_bit(input int c, input logic [8:0] d, input logic flip);
    int ones;
    ones = $countones(d & cfg_mask(c));
    if (cfg_par(c) == 1) return ((ones % 2) == 0) ^ flip;
    return ((ones % 2) == 1) ^ flip;
  endfunction

  // Reference: what the receiver must report for a frame as it went out on the wire.
  function automatic rec_t model(input int c, input logic [8:0] d, input logic p, input logic [1:0] stops);
    rec_t m;
    int   ones;
    m.inst = c;
    m.data = d & cfg_mask(c);
    ones   = $countones(m.data) + int'(p);
    if (cfg_par(c) == 1)      m.perr = ((ones % 2) == 0);
    else if (cfg_par(c) == 2) m.perr = ((ones % 2) == 1);
    else                      m.perr = 1'b0;
    m.ferr = (stops[0] == 1'b0) || (cfg_stop(c) == 2 && stops[1] == 1'b0);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic v, input int n);
    rx_line[c] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int c, input logic [8:0] d, input logic flip, input logic [1:0] stops,
                            input int gap, output logic p);
    drive(c, 1'b0, CPB);
    for (int i = 0; i < cfg_bits(c); i++) drive(c, d[i], CPB);
    p = par_bit(c, d, flip);
    if (cfg_par(c) != 0) drive(c, p, CPB);
    for (int s = 0; s < cfg_stop(c); s++) drive(c, stops[s], CPB);
    if (gap > 0) drive(c, 1'b1, gap);
  endtask

  task automatic expect_frame(input string name, input rec_t e);
    rec_t r;
    int   t;
    t = 0;
    while (rq.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rq.size() == 0) begin
      errors++;
      $display("FAIL %s: no rx_done seen, want inst %0d data %0h", name, e.inst, e.data);
    end else begin
      r = rq.pop_front();
      if (r.inst != e.inst || r.data !== e.data || r.perr !== e.perr || r.ferr !== e.ferr) begin
        errors++;
        $display("FAIL %s: got inst %0d data %0h perr %0b ferr %0b want inst %0d data %0h perr %0b ferr %0b",
                 name, r.inst, r.data, r.perr, r.ferr, e.inst, e.data, e.perr, e.ferr);
      end
    end
  endtask

  initial begin
    vec_t tbl [11];
    logic p;
    int   a, b, c;
    logic [8:0] d;
    logic flip;
    logic [1:0] stops;
    rec_t e;

    tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 20, 9'h0A5, 1'b0, 1'b0};
    tbl[1]  = '{1, 9'h035, 1'b0, 2'b11, 20, 9'h035, 1'b0, 1'b0};
    tbl[2]  = '{1, 9'h035, 1'b1, 2'b11, 20, 9'h035, 1'b1, 1'b0};
    tbl[3]  = '{2, 9'h001, 1'b0, 2'b11, 0,  9'h001, 1'b0, 1'b0};
    tbl[4]  = '{2, 9'h0FE, 1'b0, 2'b11, 20, 9'h0FE, 1'b0, 1'b0};
    tbl[5]  = '{2, 9'h03C, 1'b0, 2'b01, 20, 9'h03C, 1'b0, 1'b1};
    tbl[6]  = '{3, 9'h1FF, 1'b0, 2'b11, 20, 9'h1FF, 1'b0, 1'b0};
    tbl[7]  = '{3, 9'h100, 1'b1, 2'b11, 20, 9'h100, 1'b1, 1'b0};
    tbl[8]  = '{1, 9'h07F, 1'b0, 2'b11, 20, 9'h07F, 1'b0, 1'b0};
    tbl[9]  = '{0, 9'h000, 1'b0, 2'b11, 20, 9'h000, 1'b0, 1'b0};
    tbl[10] = '{3, 9'h0AA, 1'b0, 2'b11, 20, 9'h0AA, 1'b0, 1'b0};

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_outputs_%0d", i), {28'h0, active[i], done[i], perr[i], ferr[i]}, 32'h0);
    check("reset_data", {dat[0], dat[1], dat[2], dat[3]}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table vectors, including a back-to-back pair on the 2-stop instance (gap 0).
    for (int k = 0; k < 11; k++) begin
      a = act_cnt[tbl[k].inst];
      send_frame(tbl[k].inst, tbl[k].data, tbl[k].flip, tbl[k].stops, tbl[k].gap, p);
      expect_frame($sformatf("vec%0d", k),
                   '{inst: tbl[k].inst, data: tbl[k].exp_data, perr: tbl[k].exp_perr, ferr: tbl[k].exp_ferr});
      check($sformatf("vec%0d_active_span", k), act_cnt[tbl[k].inst] - a, span(tbl[k].inst));
    end
    check("ferr_held_until_next_done", {31'h0, ferr[2]}, 32'h1);

    // Break: stop bit low, line held low, then released; exactly one rx_done.
    b = done_cnt[0];
    send_frame(0, 9'h03C, 1'b0, 2'b00, 0, p);
    drive(0, 1'b0, 30);
    expect_frame("break_frame", '{inst: 0, data: 9'h03C, perr: 1'b0, ferr: 1'b1});
    check("break_active_low", {31'h0, active[0]}, 32'h0);
    drive(0, 1'b1, 40);
    check("break_single_done", done_cnt[0] - b, 1);
    send_frame(0, 9'h055, 1'b0, 2'b11, 20, p);
    expect_frame("after_break", '{inst: 0, data: 9'h055, perr: 1'b0, ferr: 1'b0});

    // Three-cycle glitch: rx_active for half a bit only, no rx_done.
    a = act_cnt[0];
    b = done_cnt[0];
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 30);
    check("glitch_active_span", act_cnt[0] - a, CPB / 2);
    check("glitch_no_done", done_cnt[0] - b, 0);
    send_frame(0, 9'h055, 1'b0, 2'b11, 20, p);
    expect_frame("after_glitch", '{inst: 0, data: 9'h055, perr: 1'b0, ferr: 1'b0});

    // Reset in the middle of data bit 4 of 0xFF.
    b = done_cnt[0];
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, CPB);
    drive(0, 1'b1, 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midframe_reset_outputs", {19'h0, active[0], done[0], perr[0], ferr[0], dat[0]}, 32'h0);
    rst = 1'b0;
    drive(0, 1'b1, 100);
    check("midframe_reset_no_done", done_cnt[0] - b, 0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 20, p);
    expect_frame("after_reset", '{inst: 0, data: 9'h081, perr: 1'b0, ferr: 1'b0});

    // Randomized frames against the reference model.
    for (int k = 0; k < 40; k++) begin
      c     = int'($urandom_range(0, 3));
      d     = 9'($urandom) & cfg_mask(c);
      flip  = ($urandom_range(0, 3) == 0);
      stops = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
      a     = act_cnt[c];
      send_frame(c, d, flip, stops, 0, p);
      e = model(c, d, p, stops);
      if (e.ferr) drive(c, 1'b1, int'($urandom_range(CPB, 3 * CPB)));
      else        drive(c, 1'b1, int'($urandom_range(0, 2 * CPB)));
      expect_frame($sformatf("rand%0d", k), e);
      check($sformatf("rand%0d_active_span", k), act_cnt[c] - a, span(c));
    end

    repeat (20) @(negedge clk);
    check("no_extra_frames", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
